rr_arbiter_4: RTL

Four-requester round-robin arbiter that shares one resource and drives a one-hot grant bus. A registered 2-bit winner index feeds a 2-to-4 decoder, and the decoder output is gated by grant_valid to form the grant vector. A hold counter caps how long one requester may keep the resource while others are waiting. The block sits in front of any shared datapath unit that needs a one-hot select.

---
 rtl/rr_arbiter_4_pkg.sv | 46 ++++
 rtl/rr_arbiter_4_decoder_2to4.sv | 36 +++
 rtl/rr_arbiter_4.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/rr_arbiter_4_pkg.sv
// -----------------------------------------------------------------------------
// rr_arbiter_4_pkg
//
// Shared definitions for the four-requester round-robin arbiter:
//   - requester count and index width
//   - FSM state encodings (IDLE / BUSY)
//   - rr_scan(): rotating first-set-bit search used for every arbitration
//
// No ports (package).
// -----------------------------------------------------------------------------
package rr_arbiter_4_pkg;

  localparam int NUM_REQ = 4;
  localparam int IDX_W   = 2;

  // FSM encodings kept as plain constants so older code that compares
  // against raw bit patterns keeps working.
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;

  // Result of a rotating priority scan.
  typedef struct packed {
    logic             found;
    logic [IDX_W-1:0] idx;
  } scan_t;

  // Returns the first set bit of req, scanning start, start+1, ... modulo
  // NUM_REQ. The loop runs from the far end towards start so that the
  // closest candidate is written last and therefore wins.
  function automatic scan_t rr_scan(input logic [NUM_REQ-1:0] req,
                                    input logic [IDX_W-1:0]   start);
    scan_t            res;
    logic [IDX_W-1:0] idx;
    res = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      // 2-bit addition wraps naturally, giving the modulo-4 walk.
      idx = start + IDX_W'(k);
      if (req[idx]) begin
        res.found = 1'b1;
        res.idx   = idx;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/rr_arbiter_4_decoder_2to4.sv
// -----------------------------------------------------------------------------
// decoder_2to4
//
// Purely combinational 2-to-4 one-hot decoder used to build the grant bus
// from the registered winner index.
//
// Ports:
//   s1, s0  in   select, s1 is the MSB
//   o0..o3  out  one-hot outputs, o<n> = 1 when {s1,s0} == n
// -----------------------------------------------------------------------------
module decoder_2to4
  import rr_arbiter_4_pkg::*;
(
  input  logic s1,
  input  logic s0,
  output logic o0,
  output logic o1,
  output logic o2,
  output logic o3
);

  logic [IDX_W-1:0]   sel;
  logic [NUM_REQ-1:0] dec;

  assign sel = {s1, s0};

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_dec
    assign dec[gi] = (sel == IDX_W'(gi));
  end

  assign o0 = dec[0];
  assign o1 = dec[1];
  assign o2 = dec[2];
  assign o3 = dec[3];

endmodule

// File: rtl/rr_arbiter_4.sv
// -----------------------------------------------------------------------------
// rr_arbiter_4
//
// Four-requester round-robin arbiter with a hold limit. The owner index is
// registered; the one-hot grant is decoded from that register and gated by
// grant_valid, so outputs never depend combinationally on req.
//
// Parameters:
//   MAX_HOLD  max consecutive grant cycles while someone else waits
//             (0 = unlimited)
//   CNT_W     hold counter width, 2**CNT_W must exceed MAX_HOLD
//
// Ports:
//   clk          in   system clock, all state changes on posedge
//   rst_n        in   synchronous active-low reset
//   req[3:0]     in   request vector, bit i = requester i
//   grant[3:0]   out  one-hot grant, zero when grant_valid = 0
//   grant_id     out  index of the current owner (last owner when idle)
//   grant_valid  out  resource currently granted
// -----------------------------------------------------------------------------
module rr_arbiter_4
  import rr_arbiter_4_pkg::*;
#(
  parameter int MAX_HOLD = 4,
  parameter int CNT_W    = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_id,
  output logic               grant_valid
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  // With no hold limit the counter only needs to stop somewhere; it parks
  // at all-ones and is never used for a decision.
  localparam logic [CNT_W-1:0] HOLD_SAT =
    (MAX_HOLD == 0) ? {CNT_W{1'b1}} : CNT_W'(MAX_HOLD);
  localparam logic HOLD_EN = (MAX_HOLD != 0);

  logic [0:0]         state_reg,       state_next;
  logic [IDX_W-1:0]   grant_id_reg,    grant_id_next;
  logic               grant_valid_reg, grant_valid_next;
  logic [IDX_W-1:0]   ptr_reg,         ptr_next;
  logic [CNT_W-1:0]   hold_cnt_reg,    hold_cnt_next;

  logic [NUM_REQ-1:0] owner_mask;
  logic [NUM_REQ-1:0] others;
  logic               owner_req;
  logic               hold_limit;
  logic               rotate;
  logic [IDX_W-1:0]   rot_ptr;
  scan_t              idle_scan;
  scan_t              rot_scan;
  logic [NUM_REQ-1:0] dec_out;

  // ---------------------------------------------------------------------------
  // Arbitration terms
  // ---------------------------------------------------------------------------
  assign owner_mask = NUM_REQ'(1) << grant_id_reg;
  assign owner_req  = |(req & owner_mask);
  // The owner is always excluded from re-arbitration: on release its bit is
  // already clear, on a forced rotate it must lose even if it is next in line.
  assign others     = req & ~owner_mask;
  assign rot_ptr    = grant_id_reg + IDX_W'(1);
  assign hold_limit = HOLD_EN && (hold_cnt_reg == HOLD_SAT);
  assign rotate     = !owner_req || (hold_limit && (|others));

  assign idle_scan  = rr_scan(req, ptr_reg);
  assign rot_scan   = rr_scan(others, rot_ptr);

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next       = state_reg;
    grant_id_next    = grant_id_reg;
    grant_valid_next = grant_valid_reg;
    ptr_next         = ptr_reg;
    hold_cnt_next    = hold_cnt_reg;

    case (state_reg)
      IDLE: begin
        if (idle_scan.found) begin
          state_next       = BUSY;
          grant_id_next    = idle_scan.idx;
          grant_valid_next = 1'b1;
          hold_cnt_next    = CNT_ONE;
        end
      end

      BUSY: begin
        if (rotate) begin
          // Release or forced rotate: pointer moves past the owner and the
          // next winner is chosen on this same edge (no idle bubble).
          ptr_next = rot_ptr;
          if (rot_scan.found) begin
            grant_id_next = rot_scan.idx;
            hold_cnt_next = CNT_ONE;
          end else begin
            state_next       = IDLE;
            grant_valid_next = 1'b0;
          end
        end else if (hold_cnt_reg != HOLD_SAT) begin
          hold_cnt_next = hold_cnt_reg + CNT_ONE;
        end
      end

      default: begin
        state_next       = IDLE;
        grant_valid_next = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg       <= IDLE;
      grant_id_reg    <= '0;
      grant_valid_reg <= 1'b0;
      ptr_reg         <= '0;
      hold_cnt_reg    <= '0;
    end else begin
      state_reg       <= state_next;
      grant_id_reg    <= grant_id_next;
      grant_valid_reg <= grant_valid_next;
      ptr_reg         <= ptr_next;
      hold_cnt_reg    <= hold_cnt_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Grant bus: decoded owner index gated by valid
  // ---------------------------------------------------------------------------
  decoder_2to4 u_dec (
    .s1 (grant_id_reg[1]),
    .s0 (grant_id_reg[0]),
    .o0 (dec_out[0]),
    .o1 (dec_out[1]),
    .o2 (dec_out[2]),
    .o3 (dec_out[3])
  );

  assign grant       = dec_out & {NUM_REQ{grant_valid_reg}};
  assign grant_id    = grant_id_reg;
  assign grant_valid = grant_valid_reg;

endmodule
